gate_sensor_fsm: RTL
====================

# gate_sensor_fsm

Front-end for the parking controller's gate. Turns two raw, asynchronous light-beam sensors into clean single-cycle `enter` / `exit` pulses, which drive the same-named inputs of the parking occupancy circuit directly downstream. It synchronises and debounces each beam and tracks car direction with a four-phase sequence state machine. It suppresses entries while the lot reports `full`, and flags aborted, illegal or stalled passages.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples needed before a debounced beam changes (1..255).
- `TIMEOUT_CYCLES`, default 200: maximum cycles a passage may sit in one non-idle state (2..65535).
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  reset; one clock, asynchronous, active-high.
- `sens_a`  in  1  raw outer beam, 1 = blocked, asynchronous.
- `sens_b`  in  1  raw inner beam, 1 = blocked, asynchronous.
- `full`  in  1  lot-full flag from the occupancy circuit, synchronous to `CLK`.
- `enter`  out  1  one-cycle pulse: a complete inward passage was accepted.
- `exit`  out  1  one-cycle pulse: a complete outward passage.
- `reject`  out  1  one-cycle pulse: a complete inward passage occurred while `full` = 1.
- `busy`  out  1  state is not IDLE.
- `err`  out  1  state is ERROR.

## Operation
- **Synchroniser:** two flops per sensor, giving `sa`, `sb`.
- **Debounce (per sensor):**
  - The debounced value `da` and the 8-bit counter `ca` both reset to 0.
  - If `sa` == `da`, then `ca` is set to 0.
  - Otherwise `ca` increments. On the edge where `ca` would reach `DEBOUNCE_CYCLES`, `da` takes `sa` and `ca` is set to 0.
  - `db` / `cb` are identical.
- **FSM:** uses the pair `{da,db}`. It has states IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3 and ERROR.
  - **IDLE:** 10 → IN1; 01 → OUT1; 11 → ERROR; 00 → stay.
  - **IN1:** 11 → IN2; 00 → IDLE (abort, no pulse); 01 → ERROR.
  - **IN2:** 01 → IN3; 10 → IN1 (car backs up); 00 → ERROR.
  - **IN3:** 00 → IDLE, issuing an entry event; 11 → IN2; 10 → ERROR.
  - **OUT1/OUT2/OUT3:** mirror image of the IN states with a and b swapped. OUT3 → IDLE issues an exit event.
  - **ERROR:** 00 → IDLE; any other value → stay.
  - An unchanged `{da,db}` always holds the current state.
- **Entry event:**
  - If `full` = 0 in the completing cycle, pulse `enter`.
  - If `full` = 1, pulse `reject` and do not pulse `enter`.
- **Exit event:** always pulses `exit`, regardless of `full`.
- **Timeout:**
  - A 16-bit dwell counter is set to 0 on every state change and while in IDLE or ERROR.
  - In any other state it increments each cycle.
  - When it reaches `TIMEOUT_CYCLES - 1` with no transition pending, the next edge moves the FSM to ERROR.
  - A legal transition on that same edge takes priority over the timeout.
- **Exclusivity:** `enter`, `exit` and `reject` are mutually exclusive. Each is high for exactly one cycle per completed passage.

## Timing
- **Reset:** during and after `RST`, all outputs are 0, state = IDLE, and all synchroniser, debounce and dwell registers are 0. Asserting reset mid-passage abandons the passage with no pulse.
- **Registered outputs:** all outputs are registered. Pulses assert on the same edge the FSM enters IDLE.
- **Latency:** a raw change first sampled at edge 1 updates the debounced value at edge `DEBOUNCE_CYCLES` + 2. The FSM state moves at edge `DEBOUNCE_CYCLES` + 3. The final-beam clear to the `enter` / `exit` pulse is therefore `DEBOUNCE_CYCLES` + 3 edges.
- **Status outputs:** `busy` and `err` follow the state register with no extra delay.
- **Glitch rejection:** a raw glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never changes `da` / `db`.
- **Sampling of `full`:** `full` is sampled on the completing edge only. A change in `full` earlier in the passage has no effect.

## Test plan
Benches use `DEBOUNCE_CYCLES` = 2 and `TIMEOUT_CYCLES` = 20, and hold every raw level for at least 6 cycles.
- **Reset:** assert `RST` for 3 cycles with sensors toggling → all outputs 0 throughout. After release with sensors at 00 → `busy` = 0.
- **Accepted entry:** `full` = 0, raw sequence 00,10,11,01,00 → exactly one `enter` pulse, 5 edges after the final 00 is sampled; `exit` = `reject` = 0.
- **Exit and full lot:**
  - Sequence 00,01,11,10,00 → one `exit` pulse.
  - Repeat the entry sequence with `full` = 1 → one `reject` pulse, `enter` stays 0.
- **Abort and back-up:**
  - 10,00 → no pulse, `busy` returns to 0.
  - 10,11,10,11,01,00 → one `enter` pulse.
  - A 1-cycle raw glitch on `sens_a` in IDLE → `busy` stays 0.
- **Illegal jump:** 10 then 01 → `err` = 1. `err` holds until the beams read 00, then `busy` = 0 with no pulse issued.
- **Timeout:** hold 11 from IN2 for 25 cycles → `err` rises exactly 20 cycles after entering IN2. Clearing to 00 returns to IDLE with no pulse.

Source files
------------

// File: rtl/gate_sensor_fsm.sv
// Gate sensor front-end: sync + debounce two light beams, track car direction, emit enter/exit/reject pulses.
// Latency: raw change to debounced value DEBOUNCE_CYCLES+2 edges, to FSM/pulse DEBOUNCE_CYCLES+3 edges.
// Backpressure: none; pulses are single-cycle and must be consumed by the occupancy circuit directly.
//
// Ports:
//   CLK, RST       clock, asynchronous active-high reset
//   sens_a/sens_b  raw outer/inner beams (1 = blocked), asynchronous
//   full           lot-full flag, synchronous, sampled only on the completing edge of an entry
//   enter/exit     one-cycle pulses for completed inward/outward passages
//   reject         one-cycle pulse for an inward passage completed while full
//   busy/err       state != IDLE / state == ERROR
module gate_sensor_fsm #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 200
) (
   input  logic CLK,
   input  logic RST,
   input  logic sens_a,
   input  logic sens_b,
   input  logic full,
   output logic enter,
   output logic exit,
   output logic reject,
   output logic busy,
   output logic err
);

   typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ERROR} state_t;

   // A debounce counter sitting at DB_LAST reaches DEBOUNCE_CYCLES on the next edge.
   localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   // Bit 1 carries beam a, bit 0 carries beam b, so deb reads directly as {da,db}.
   logic [1:0]      sync1;
   logic [1:0]      sync2;
   logic [1:0]      deb;
   logic [1:0][7:0] cnt;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] dwell;
   logic        entry_evt;
   logic        exit_evt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {sens_a, sens_b};
         sync2 <= sync1;
      end
   end

   // Any sample agreeing with the debounced value restarts the count, so only
   // DEBOUNCE_CYCLES consecutive disagreeing samples can flip the output.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         deb <= '0;
         cnt <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DB_LAST) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      entry_evt = 1'b0;
      exit_evt  = 1'b0;
      case (state)
         IDLE: case (deb)
            2'b10:   state_nxt = IN1;
            2'b01:   state_nxt = OUT1;
            2'b11:   state_nxt = ERROR;
            default: state_nxt = IDLE;
         endcase
         IN1: case (deb)
            2'b11:   state_nxt = IN2;
            2'b00:   state_nxt = IDLE;
            2'b01:   state_nxt = ERROR;
            default: state_nxt = IN1;
         endcase
         IN2: case (deb)
            2'b01:   state_nxt = IN3;
            2'b10:   state_nxt = IN1;
            2'b00:   state_nxt = ERROR;
            default: state_nxt = IN2;
         endcase
         IN3: case (deb)
            2'b00: begin
               state_nxt = IDLE;
               entry_evt = 1'b1;
            end
            2'b11:   state_nxt = IN2;
            2'b10:   state_nxt = ERROR;
            default: state_nxt = IN3;
         endcase
         OUT1: case (deb)
            2'b11:   state_nxt = OUT2;
            2'b00:   state_nxt = IDLE;
            2'b10:   state_nxt = ERROR;
            default: state_nxt = OUT1;
         endcase
         OUT2: case (deb)
            2'b10:   state_nxt = OUT3;
            2'b01:   state_nxt = OUT1;
            2'b00:   state_nxt = ERROR;
            default: state_nxt = OUT2;
         endcase
         OUT3: case (deb)
            2'b00: begin
               state_nxt = IDLE;
               exit_evt  = 1'b1;
            end
            2'b11:   state_nxt = OUT2;
            2'b01:   state_nxt = ERROR;
            default: state_nxt = OUT3;
         endcase
         ERROR: begin
            if (deb == 2'b00) state_nxt = IDLE;
         end
         default: state_nxt = ERROR;
      endcase
      // Timeout only fires when the beams ask the FSM to stay put; a real move wins.
      if (state_nxt == state && state != IDLE && state != ERROR && dwell == TO_LAST) begin
         state_nxt = ERROR;
      end
   end

   // Dwell and outputs are derived from state_nxt so they change on the same edge as the state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dwell  <= '0;
         enter  <= 1'b0;
         exit   <= 1'b0;
         reject <= 1'b0;
         busy   <= 1'b0;
         err    <= 1'b0;
      end else begin
         if (state_nxt != state || state_nxt == IDLE || state_nxt == ERROR) begin
            dwell <= '0;
         end else begin
            dwell <= dwell + 16'd1;
         end
         enter  <= entry_evt & ~full;
         reject <= entry_evt & full;
         exit   <= exit_evt;
         busy   <= (state_nxt != IDLE);
         err    <= (state_nxt == ERROR);
      end
   end

endmodule
